// File: rtl/pwm_setpoint_ramp_if.sv
// Request/response bundle between the processor/PWM side (master) and the
// setpoint ramp block (slave).
interface pwm_setpoint_ramp_if #(
    parameter int WIDTH = 28
);
    logic [WIDTH-1:0] duty_req;
    logic [WIDTH-1:0] period_req;
    logic             stop_sw;
    logic             period_end;
    logic [WIDTH-1:0] duty_out;
    logic [WIDTH-1:0] period_out;
    logic [1:0]       state_out;
    logic             safe;

    modport master (
        output duty_req, period_req, stop_sw, period_end,
        input  duty_out, period_out, state_out, safe
    );

    modport slave (
        input  duty_req, period_req, stop_sw, period_end,
        output duty_out, period_out, state_out, safe
    );
endinterface

// File: rtl/pwm_setpoint_ramp.sv
// Slew-limited duty/period setpoints for a PWM stage, updated only at period
// boundaries, with a debounced stop switch forcing a ramp-down to zero.
module pwm_setpoint_ramp #(
    parameter int WIDTH           = 28,
    parameter int RAMP_STEP       = 500,
    parameter int STOP_STEP       = 2000,
    parameter int MIN_PERIOD      = 1000,
    parameter int RESET_PERIOD    = 1000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset_n,
    pwm_setpoint_ramp_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        SAFE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10,
        BAD      = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [1:0]       sync_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             stop_db_q, stop_db_d;

    // Stop switch: 2-flop synchronizer then a stability counter
    always_comb begin
        cnt_d     = '0;
        stop_db_d = stop_db_q;
        if (sync_q[1] != stop_db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stop_db_d = sync_q[1];
            else                                   cnt_d     = cnt_q + 1'b1;
        end
    end

    // Ramp arithmetic: differences only taken in the known-positive direction
    logic [WIDTH-1:0] p_clamp, target, diff, step, ramp_raw, ramp_val, stop_val;
    logic             going_up;

    always_comb begin
        p_clamp  = (bus.period_req < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : bus.period_req;
        target   = (bus.duty_req < p_clamp) ? bus.duty_req : p_clamp;
        going_up = (duty_q < target);
        diff     = going_up ? (target - duty_q) : (duty_q - target);
        step     = (diff < WIDTH'(RAMP_STEP)) ? diff : WIDTH'(RAMP_STEP);
        ramp_raw = going_up ? (duty_q + step) : (duty_q - step);
        // a shrinking period cuts duty immediately rather than slewing
        ramp_val = (ramp_raw > p_clamp) ? p_clamp : ramp_raw;
        stop_val = (duty_q > WIDTH'(STOP_STEP)) ? (duty_q - WIDTH'(STOP_STEP)) : '0;
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        period_d = period_q;
        case (state_q)
            SAFE: begin
                duty_d = '0;
                if (bus.period_end) begin
                    period_d = p_clamp;
                    // re-arm only once the processor has written zero duty
                    if (!stop_db_q && bus.duty_req == '0) state_d = RUN;
                end
            end
            RUN: begin
                if (stop_db_d) begin
                    state_d = STOPPING;
                end else if (bus.period_end) begin
                    period_d = p_clamp;
                    duty_d   = ramp_val;
                end
            end
            STOPPING: begin
                if (bus.period_end) begin
                    duty_d = stop_val;
                    if (stop_val == '0) state_d = SAFE;
                end
            end
            default: begin
                state_d = SAFE;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SAFE;
            duty_q    <= '0;
            period_q  <= WIDTH'(RESET_PERIOD);
            sync_q    <= '0;
            cnt_q     <= '0;
            stop_db_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            sync_q    <= {sync_q[0], bus.stop_sw};
            cnt_q     <= cnt_d;
            stop_db_q <= stop_db_d;
        end
    end

    assign bus.duty_out   = duty_q;
    assign bus.period_out = period_q;
    assign bus.state_out  = state_q;
    assign bus.safe       = (state_q == SAFE);
endmodule

// File: tb/tb_pwm_setpoint_ramp.sv
// Directed bench for pwm_setpoint_ramp with a short debounce window.
module tb_pwm_setpoint_ramp;
    localparam int W  = 28;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pwm_setpoint_ramp_if #(.WIDTH(W)) bus ();

    pwm_setpoint_ramp #(
        .WIDTH(W), .RAMP_STEP(500), .STOP_STEP(2000), .MIN_PERIOD(1000),
        .RESET_PERIOD(1000000), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pe();
        @(negedge clk); bus.period_end = 1'b1;
        @(negedge clk); bus.period_end = 1'b0;
    endtask

    task automatic pe_duty(input string tag, input int unsigned exp);
        pe();
        chk(tag, bus.duty_out, exp);
    endtask

    initial begin
        bus.duty_req   = '0;
        bus.period_req = W'(50000);
        bus.stop_sw    = 1'b0;
        bus.period_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty",   bus.duty_out, 0);
        chk("rst_period", bus.period_out, 1000000);
        chk("rst_state",  bus.state_out, 0);
        chk("rst_safe",   bus.safe, 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("frozen_period", bus.period_out, 1000000);

        // 1: arm into RUN
        pe();
        chk("t1_state",  bus.state_out, 1);
        chk("t1_safe",   bus.safe, 0);
        chk("t1_period", bus.period_out, 50000);
        chk("t1_duty",   bus.duty_out, 0);

        // 2: ramp up and down
        bus.duty_req = W'(1800);
        pe_duty("up1", 500);
        pe_duty("up2", 1000);
        pe_duty("up3", 1500);
        pe_duty("up4", 1800);
        pe_duty("hold", 1800);
        bus.duty_req = '0;
        pe_duty("dn1", 1300);
        pe_duty("dn2", 800);
        pe_duty("dn3", 300);
        pe_duty("dn4", 0);

        // 3: period shrink and min clamp
        bus.duty_req = W'(1800);
        repeat (4) pe();
        chk("t3_pre", bus.duty_out, 1800);
        bus.period_req = W'(1200);
        pe();
        chk("shrink_period", bus.period_out, 1200);
        chk("shrink_duty",   bus.duty_out, 1200);
        bus.period_req = W'(10);
        pe();
        chk("minclamp_period", bus.period_out, 1000);
        chk("minclamp_duty",   bus.duty_out, 1000);

        // 4: glitch rejected, then debounced stop and ramp-down
        bus.period_req = W'(50000);
        bus.duty_req   = W'(5000);
        repeat (8) pe();
        chk("t4_pre", bus.duty_out, 5000);
        bus.stop_sw = 1'b1;
        repeat (DB - 1) @(negedge clk);
        bus.stop_sw = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_state", bus.state_out, 1);
        bus.stop_sw = 1'b1;
        repeat (DB + 1) @(negedge clk);
        chk("db_early_state", bus.state_out, 1);
        @(negedge clk);
        chk("db_state", bus.state_out, 2);
        chk("db_duty",  bus.duty_out, 5000);
        pe_duty("stop1", 3000);
        chk("stop1_state", bus.state_out, 2);
        pe_duty("stop2", 1000);
        pe_duty("stop3", 0);
        chk("stop_safe_state", bus.state_out, 0);
        chk("stop_safe",       bus.safe, 1);
        chk("stop_period",     bus.period_out, 50000);

        // 5: re-arm interlock
        bus.stop_sw    = 1'b0;
        bus.duty_req   = W'(4000);
        bus.period_req = W'(60000);
        repeat (12) @(negedge clk);
        pe();
        chk("lock_state",  bus.state_out, 0);
        chk("lock_duty",   bus.duty_out, 0);
        chk("safe_period", bus.period_out, 60000);
        bus.duty_req = '0;
        pe();
        chk("rearm_state", bus.state_out, 1);

        // 6: async reset mid-ramp, then stop coincident with period_end
        bus.duty_req = W'(3000);
        repeat (6) pe();
        chk("t6_pre", bus.duty_out, 3000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_duty",   bus.duty_out, 0);
        chk("async_period", bus.period_out, 1000000);
        chk("async_state",  bus.state_out, 0);
        @(negedge clk) reset_n = 1'b1;
        bus.duty_req = '0;
        pe();
        chk("t6_run", bus.state_out, 1);
        bus.duty_req = W'(2000);
        pe_duty("t6_up1", 500);
        pe_duty("t6_up2", 1000);
        bus.stop_sw = 1'b1;
        repeat (DB + 1) @(negedge clk);
        bus.period_end = 1'b1;
        @(negedge clk);
        bus.period_end = 1'b0;
        chk("coinc_state", bus.state_out, 2);
        chk("coinc_duty",  bus.duty_out, 1000);
        pe_duty("coinc_stop", 0);
        chk("coinc_safe", bus.state_out, 0);
        bus.duty_req = '0;
        pe();
        chk("stopheld_state", bus.state_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_setpoint_ramp.md
Name: pwm_setpoint_ramp

Overview:
- Upstream of the PWM counter stage; feeds it duty (high time) and period (terminal count) in clock cycles.
- Takes raw processor-written duty/period requests and applies a slew-rate limit.
- Updates outputs only at PWM period boundaries, so each PWM cycle is glitch-free.
- A debounced stop switch forces a controlled ramp-down to zero duty, followed by a re-arm interlock.

Parameters:
WIDTH, 28, width of duty/period values (clock cycles)
RAMP_STEP, 500, max duty change per PWM period in RUN
STOP_STEP, 2000, duty decrement per PWM period in STOPPING
MIN_PERIOD, 1000, lower clamp applied to period_req
RESET_PERIOD, 1000000, period_out value after reset
DEBOUNCE_CYCLES, 1000000, cycles stop input must be stable to register a change

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
duty_req  input  WIDTH  requested high time from processor PIO
period_req  input  WIDTH  requested period terminal count from processor PIO
stop_sw  input  1  raw stop switch, asynchronous, 1 = stop
period_end  input  1  one-cycle pulse from PWM stage on the cycle its counter clears
duty_out  output  WIDTH  duty value to PWM stage
period_out  output  WIDTH  period value to PWM stage
state_out  output  2  current FSM state encoding
safe  output  1  1 while in SAFE state

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: duty_out=0, period_out=RESET_PERIOD, state=SAFE (state_out=00), safe=1. Synchronizer, debounce counter and stop_db are all cleared.
- Reset asserted mid-operation takes duty_out to 0 immediately, without waiting for period_end.
- Stop path:
  - stop_sw passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from stop_db, and clears when they match.
  - stop_db takes the new value when the counter reaches DEBOUNCE_CYCLES-1; the counter then clears.
  - Effective latency is 2+DEBOUNCE_CYCLES cycles. Pulses shorter than DEBOUNCE_CYCLES are ignored.
- All duty_out/period_out updates happen only on a clock edge where period_end=1. New values are visible the next cycle, while the PWM counter is at 0, so they apply to the whole following period.
- FSM states: SAFE=00, RUN=01, STOPPING=10. Encoding 11 is unreachable and recovers to SAFE with duty_out=0.
- SAFE:
  - duty_out held at 0.
  - period_out tracks max(period_req, MIN_PERIOD) at each period_end.
  - Goes to RUN at a period_end when stop_db=0 and duty_req==0 (re-arm interlock: the processor must write zero duty first).
- RUN, at each period_end:
  - P = max(period_req, MIN_PERIOD); period_out <= P.
  - T = min(duty_req, P).
  - If duty_out < T: duty_out <= duty_out + min(RAMP_STEP, T-duty_out).
  - If duty_out > T: duty_out <= duty_out - min(RAMP_STEP, duty_out-T).
  - The result is then clamped to at most P, so a shrinking period cuts duty immediately.
- RUN to STOPPING: on the edge where stop_db becomes 1, no period_end is needed. duty_out is unchanged on that edge.
- STOPPING, at each period_end:
  - period_out is held.
  - duty_out <= duty_out - min(STOP_STEP, duty_out), saturating at 0.
  - When the written value is 0, go to SAFE on the same edge.
  - Entering with duty_out=0 reaches SAFE at the first period_end.
- Simultaneous stop_db rise and period_end in RUN: STOPPING wins, and that edge applies no RUN ramp.
- stop_db falling during STOPPING does not abort; the ramp-down completes and re-arm goes via SAFE.
- Arithmetic is unsigned WIDTH-bit; no intermediate wraps. Differences are computed only in the direction that is known positive.
- No period_end pulses means outputs are frozen, except the immediate reset clear.
- safe = (state==SAFE). state_out is registered.

Test Plan:
1. Reset, then release with duty_req=0 and period_req=50000, pulse period_end -> duty_out=0, period_out=50000, state RUN after first period_end.
2. In RUN from duty 0, set duty_req=1800 with RAMP_STEP=500 -> duty_out steps 500, 1000, 1500, 1800 on successive period_end, then holds. Then duty_req=0 -> 1300, 800, 300, 0.
3. duty_out=1800 with period_req lowered to 1200 -> at next period_end period_out=1200, duty_out=1200. period_req=10 -> period_out=1000 (MIN_PERIOD clamp).
4. duty_out=5000; hold stop_sw high for DEBOUNCE_CYCLES+2 -> STOPPING. duty_out goes 3000, 1000, 0 on period_ends, then SAFE. Glitch of DEBOUNCE_CYCLES-1 cycles -> no state change.
5. In SAFE with stop_sw released but duty_req=4000 -> stays SAFE, duty_out=0. Write duty_req=0 -> RUN at next period_end.
6. Assert reset_n low mid-ramp at duty_out=3000 -> duty_out=0 and period_out=RESET_PERIOD asynchronously. stop_db rising coincident with period_end -> STOPPING, duty unchanged that edge.
